// File: rtl/mux_arb_nbw.sv
// N-channel arbitrating mux with a single registered output stage (fixed-select or round-robin).
// Optional build macro MUX_ARB_PARITY_EN adds the registered even-parity output OutPar.
module mux_arb_nbw #(
    parameter int WIDTH = 16,
    parameter int NCH   = 4,
    parameter int SELW  = 2
) (
    input  logic                 CLK,
    input  logic                 Reset,
    input  logic [NCH*WIDTH-1:0] In,
    input  logic [NCH-1:0]       InValid,
    output logic [NCH-1:0]       InReady,
    input  logic [1:0]           OP,
    input  logic [SELW-1:0]      Sel,
    output logic [WIDTH-1:0]     Out,
    output logic                 OutValid,
    input  logic                 OutReady,
`ifdef MUX_ARB_PARITY_EN
    output logic                 OutPar,
`endif
    output logic [SELW-1:0]      OutSel
);

    localparam int SPAN = 1 << SELW;

    logic [SELW-1:0]  ptr;
    logic             open_reg;
    logic [SPAN-1:0]  fixed_hit;
    logic [NCH-1:0]   rr_hit;
    logic [NCH-1:0]   grant;
    logic             rr_found;
    logic [SELW:0]    scan;
    logic             xfer;
    logic [WIDTH-1:0] xfer_data;
    logic [SELW-1:0]  xfer_idx;
    logic [SELW-1:0]  ptr_next;

    assign open_reg = !OutValid || OutReady;
    assign InReady  = grant;

    // fixed_hit spans the full select range so a Sel beyond NCH-1 simply falls off the top
    always_comb begin
        fixed_hit      = '0;
        fixed_hit[Sel] = 1'b1;
        rr_hit         = '0;
        rr_found       = 1'b0;
        scan           = '0;
        for (int i = 0; i < NCH; i++) begin
            scan = {1'b0, ptr} + (SELW+1)'(i);
            if (scan >= (SELW+1)'(NCH))
                scan = scan - (SELW+1)'(NCH);
            if (!rr_found && InValid[scan[SELW-1:0]]) begin
                rr_hit[scan[SELW-1:0]] = 1'b1;
                rr_found               = 1'b1;
            end
        end
        case (OP)
            2'b00:   grant = fixed_hit[NCH-1:0];
            2'b01:   grant = rr_hit;
            default: grant = '0;
        endcase
        if (Reset || !open_reg)
            grant = '0;
    end

    always_comb begin
        xfer      = 1'b0;
        xfer_data = '0;
        xfer_idx  = '0;
        for (int k = 0; k < NCH; k++) begin
            if (grant[k] && InValid[k]) begin
                xfer      = 1'b1;
                xfer_data = In[k*WIDTH +: WIDTH];
                xfer_idx  = SELW'(k);
            end
        end
        ptr_next = (xfer_idx == SELW'(NCH-1)) ? '0 : xfer_idx + SELW'(1);
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            Out      <= '0;
            OutValid <= 1'b0;
            OutSel   <= '0;
            ptr      <= '0;
`ifdef MUX_ARB_PARITY_EN
            OutPar   <= 1'b0;
`endif
        end else if (open_reg) begin
            if (xfer) begin
                Out      <= xfer_data;
                OutValid <= 1'b1;
                OutSel   <= xfer_idx;
`ifdef MUX_ARB_PARITY_EN
                OutPar   <= ^xfer_data;
`endif
                if (OP == 2'b01)
                    ptr <= ptr_next;
            end else begin
                OutValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_arb_nbw.sv
// Bench for mux_arb_nbw: directed cycle table, then randomized traffic against a queue-free reference model.
module tb_mux_arb_nbw;

    localparam int WIDTH = 16;
    localparam int NCH   = 4;
    localparam int SELW  = 2;

    logic                 CLK = 1'b0;
    logic                 Reset;
    logic [NCH*WIDTH-1:0] In;
    logic [NCH-1:0]       InValid;
    logic [NCH-1:0]       InReady;
    logic [1:0]           OP;
    logic [SELW-1:0]      Sel;
    logic [WIDTH-1:0]     Out;
    logic                 OutValid;
    logic                 OutReady;
    logic [SELW-1:0]      OutSel;
`ifdef MUX_ARB_PARITY_EN
    logic                 OutPar;
`endif

    always #5 CLK = ~CLK;

    mux_arb_nbw #(.WIDTH(WIDTH), .NCH(NCH), .SELW(SELW)) dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .In       (In),
        .InValid  (InValid),
        .InReady  (InReady),
        .OP       (OP),
        .Sel      (Sel),
        .Out      (Out),
        .OutValid (OutValid),
        .OutReady (OutReady),
`ifdef MUX_ARB_PARITY_EN
        .OutPar   (OutPar),
`endif
        .OutSel   (OutSel)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic [1:0]  op;
        logic [1:0]  sel;
        logic [3:0]  ival;
        logic        ordy;
        logic [3:0]  rdy;
        logic        ov;
        logic [15:0] out;
        logic [1:0]  osel;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic [1:0] op, logic [1:0] sel, logic [3:0] ival, logic ordy,
                                logic [3:0] rdy, logic ov, logic [15:0] out, logic [1:0] osel);
        vec_t v;
        v.rst = rst; v.op = op; v.sel = sel; v.ival = ival; v.ordy = ordy;
        v.rdy = rdy; v.ov = ov; v.out = out; v.osel = osel;
        return v;
    endfunction

    // reference model state
    logic             m_ov;
    logic [WIDTH-1:0] m_out;
    int               m_sel;
    int               m_ptr;
    logic             m_par;

    initial begin
        logic [NCH-1:0] exp_rdy;
        logic           opn;
        logic [1:0]     pick;

        Reset = 1'b1; OP = 2'b10; Sel = '0; InValid = '0; OutReady = 1'b0;
        In = {16'hD3D3, 16'hA5A5, 16'hB2B2, 16'hC1C1};

        //         rst op     sel ival     ordy rdy      ov  out       osel
        tbl.push_back(mk(1, 2'b01, 0, 4'b1111, 1, 4'b0000, 0, 16'h0000, 0));
        tbl.push_back(mk(0, 2'b00, 2, 4'b1111, 1, 4'b0100, 1, 16'hA5A5, 2));
        tbl.push_back(mk(1, 2'b00, 2, 4'b1111, 1, 4'b0000, 0, 16'h0000, 0));
        tbl.push_back(mk(0, 2'b01, 0, 4'b1111, 1, 4'b0001, 1, 16'hC1C1, 0));
        tbl.push_back(mk(0, 2'b01, 0, 4'b1111, 1, 4'b0010, 1, 16'hB2B2, 1));
        tbl.push_back(mk(0, 2'b01, 0, 4'b1111, 1, 4'b0100, 1, 16'hA5A5, 2));
        tbl.push_back(mk(0, 2'b01, 0, 4'b1111, 1, 4'b1000, 1, 16'hD3D3, 3));
        tbl.push_back(mk(0, 2'b01, 0, 4'b1111, 1, 4'b0001, 1, 16'hC1C1, 0));
        tbl.push_back(mk(0, 2'b01, 0, 4'b1111, 1, 4'b0010, 1, 16'hB2B2, 1));
        tbl.push_back(mk(1, 2'b01, 0, 4'b1111, 1, 4'b0000, 0, 16'h0000, 0));
        tbl.push_back(mk(0, 2'b01, 0, 4'b1010, 0, 4'b0010, 1, 16'hB2B2, 1));
        tbl.push_back(mk(0, 2'b01, 0, 4'b1010, 0, 4'b0000, 1, 16'hB2B2, 1));
        tbl.push_back(mk(0, 2'b01, 0, 4'b1010, 0, 4'b0000, 1, 16'hB2B2, 1));
        tbl.push_back(mk(0, 2'b01, 0, 4'b1010, 1, 4'b1000, 1, 16'hD3D3, 3));
        tbl.push_back(mk(0, 2'b01, 0, 4'b1010, 1, 4'b0010, 1, 16'hB2B2, 1));
        tbl.push_back(mk(0, 2'b10, 0, 4'b1111, 1, 4'b0000, 0, 16'hB2B2, 1));
        tbl.push_back(mk(0, 2'b11, 0, 4'b1111, 0, 4'b0000, 0, 16'hB2B2, 1));
        tbl.push_back(mk(0, 2'b00, 1, 4'b0000, 1, 4'b0010, 0, 16'hB2B2, 1));
        tbl.push_back(mk(0, 2'b01, 0, 4'b0100, 1, 4'b0100, 1, 16'hA5A5, 2));
        tbl.push_back(mk(1, 2'b01, 0, 4'b1111, 1, 4'b0000, 0, 16'h0000, 0));
        tbl.push_back(mk(0, 2'b01, 0, 4'b1111, 1, 4'b0001, 1, 16'hC1C1, 0));
        tbl.push_back(mk(0, 2'b00, 3, 4'b1111, 0, 4'b0000, 1, 16'hC1C1, 0));
        tbl.push_back(mk(0, 2'b00, 3, 4'b1111, 1, 4'b1000, 1, 16'hD3D3, 3));
        tbl.push_back(mk(0, 2'b01, 0, 4'b1111, 1, 4'b0010, 1, 16'hB2B2, 1));

        foreach (tbl[i]) begin
            @(negedge CLK);
            Reset = tbl[i].rst; OP = tbl[i].op; Sel = tbl[i].sel;
            InValid = tbl[i].ival; OutReady = tbl[i].ordy;
            #1;
            chk("tbl_inready", i, 64'(InReady), 64'(tbl[i].rdy));
            @(posedge CLK);
            #1;
            chk("tbl_outvalid", i, 64'(OutValid), 64'(tbl[i].ov));
            chk("tbl_out", i, 64'(Out), 64'(tbl[i].out));
            chk("tbl_outsel", i, 64'(OutSel), 64'(tbl[i].osel));
        end

`ifdef MUX_ARB_PARITY_EN
        @(negedge CLK);
        Reset = 1'b0; OP = 2'b00; Sel = 2'd0; InValid = 4'b0001; OutReady = 1'b1;
        In[15:0] = 16'h0007;
        @(posedge CLK); #1;
        chk("par_0007", 0, 64'(OutPar), 64'(1));
        @(negedge CLK);
        In[15:0] = 16'h0003;
        @(posedge CLK); #1;
        chk("par_0003", 1, 64'(OutPar), 64'(0));
`endif

        m_ov = 1'b0; m_out = '0; m_sel = 0; m_ptr = 0; m_par = 1'b0;
        for (int n = 0; n < 600; n++) begin
            @(negedge CLK);
            Reset = (n == 0) || ($urandom_range(0, 39) == 0);
            pick = 2'($urandom_range(0, 3));
            OP = (pick == 2'd3) ? 2'(2 + $urandom_range(0, 1)) : (pick == 2'd0 ? 2'b00 : 2'b01);
            Sel = SELW'($urandom_range(0, NCH-1));
            InValid = NCH'($urandom);
            OutReady = ($urandom_range(0, 3) != 0);
            In = {$urandom, $urandom};

            opn = !m_ov || OutReady;
            exp_rdy = '0;
            if (!Reset && opn) begin
                if (OP == 2'b00) begin
                    exp_rdy[Sel] = 1'b1;
                end else if (OP == 2'b01) begin
                    for (int d = NCH-1; d >= 0; d--)
                        if (InValid[(m_ptr + d) % NCH]) begin
                            exp_rdy = '0;
                            exp_rdy[(m_ptr + d) % NCH] = 1'b1;
                        end
                end
            end
            #1;
            chk("rnd_inready", n, 64'(InReady), 64'(exp_rdy));

            if (Reset) begin
                m_ov = 1'b0; m_out = '0; m_sel = 0; m_ptr = 0; m_par = 1'b0;
            end else if (opn) begin
                m_ov = 1'b0;
                for (int c = 0; c < NCH; c++)
                    if (exp_rdy[c] && InValid[c]) begin
                        m_ov  = 1'b1;
                        m_out = In[c*WIDTH +: WIDTH];
                        m_sel = c;
                        m_par = ^In[c*WIDTH +: WIDTH];
                        if (OP == 2'b01) m_ptr = (c + 1) % NCH;
                    end
            end
            @(posedge CLK);
            #1;
            chk("rnd_outvalid", n, 64'(OutValid), 64'(m_ov));
            chk("rnd_out", n, 64'(Out), 64'(m_out));
            chk("rnd_outsel", n, 64'(OutSel), 64'(m_sel));
`ifdef MUX_ARB_PARITY_EN
            chk("rnd_outpar", n, 64'(OutPar), 64'(m_par));
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
